// File: rtl/keypad_cmd_encoder_if.sv
// Keypad-side bundle of the command encoder: row sense in, column drive and
// the single-cycle calculator command out.
interface keypad_cmd_encoder_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] cmd;
  logic       cmd_valid;

  modport master (
    input  row_n,
    output col_n,
    output cmd,
    output cmd_valid
  );

  modport slave (
    output row_n,
    input  col_n,
    input  cmd,
    input  cmd_valid
  );
endinterface

// File: rtl/keypad_cmd_encoder.sv
// 4x4 active-low keypad scanner with tick-based debounce; emits one registered
// calculator command code per accepted press and waits for release before rescanning.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  keypad_cmd_encoder_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       IDLE_CODE = 4'b1101;

  typedef enum logic [1:0] {
    S_SCAN = 2'd0,
    S_DEB  = 2'd1,
    S_EMIT = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [3:0]       r_col_n;
  logic [1:0]       r_row;
  logic [CNT_W-1:0] r_match;
  logic [CNT_W-1:0] r_rel;
  logic [3:0]       r_cmd;
  logic             r_valid;

  logic             w_tick;
  logic [3:0]       w_low;
  logic             w_none;
  logic             w_single;
  logic [1:0]       w_row_idx;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_code;
  logic [3:0]       w_col_next;
  logic [CNT_W-1:0] w_match_nxt;
  logic [CNT_W-1:0] w_rel_nxt;

  // Row/column position to calculator command; r3c3 maps to the idle code and never emits.
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b0000: code = 4'b0001;
      4'b0001: code = 4'b0010;
      4'b0010: code = 4'b0011;
      4'b0011: code = 4'b1010;
      4'b0100: code = 4'b0100;
      4'b0101: code = 4'b0101;
      4'b0110: code = 4'b0110;
      4'b0111: code = 4'b1011;
      4'b1000: code = 4'b0111;
      4'b1001: code = 4'b1000;
      4'b1010: code = 4'b1001;
      4'b1011: code = 4'b1100;
      4'b1100: code = 4'b1111;
      4'b1101: code = 4'b0000;
      4'b1110: code = 4'b1110;
      default: code = IDLE_CODE;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Two-flop synchronizer on the asynchronous row inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= kp.row_n;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running scan divider.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  // Decode of the synchronized rows and the frozen column.
  always_comb begin
    w_tick      = (r_div == DIV_LAST);
    w_low       = ~r_sync2;
    w_none      = (w_low == 4'b0000);
    w_single    = !w_none && ((w_low & (w_low - 4'd1)) == 4'b0000);
    w_row_idx   = onehot_idx(w_low);
    w_col_idx   = onehot_idx(~r_col_n);
    w_code      = map_key(w_row_idx, w_col_idx);
    w_col_next  = {r_col_n[2:0], r_col_n[3]};
    w_match_nxt = r_match + CNT_ONE;
    w_rel_nxt   = r_rel + CNT_ONE;
  end

  // Scan / debounce / emit / release state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_SCAN;
      r_col_n <= 4'b1110;
      r_row   <= 2'd0;
      r_match <= '0;
      r_rel   <= '0;
      r_cmd   <= IDLE_CODE;
      r_valid <= 1'b0;
    end else begin
      r_cmd   <= IDLE_CODE;
      r_valid <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (w_tick) begin
            if (w_single) begin
              r_row   <= w_row_idx;
              r_match <= CNT_ONE;
              if (CNT_ONE == CNT_TOP) begin
                r_state <= S_EMIT;
                r_cmd   <= w_code;
                r_valid <= (w_code != IDLE_CODE);
              end else begin
                r_state <= S_DEB;
              end
            end else begin
              r_col_n <= w_col_next;
            end
          end
        end
        S_DEB: begin
          if (w_tick) begin
            if (w_single && (w_row_idx == r_row)) begin
              r_match <= w_match_nxt;
              if (w_match_nxt == CNT_TOP) begin
                r_state <= S_EMIT;
                r_cmd   <= w_code;
                r_valid <= (w_code != IDLE_CODE);
              end
            end else begin
              r_match <= '0;
              r_col_n <= w_col_next;
              r_state <= S_SCAN;
            end
          end
        end
        S_EMIT: begin
          r_match <= '0;
          r_rel   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_tick) begin
            if (!w_none) begin
              r_rel <= '0;
            end else if (w_rel_nxt == CNT_TOP) begin
              r_rel   <= '0;
              r_col_n <= w_col_next;
              r_state <= S_SCAN;
            end else begin
              r_rel <= w_rel_nxt;
            end
          end
        end
        default: begin
          r_state <= S_SCAN;
        end
      endcase
    end
  end

  assign kp.col_n     = r_col_n;
  assign kp.cmd       = r_cmd;
  assign kp.cmd_valid = r_valid;

endmodule
